gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Computes the greatest common divisor of two unsigned operands by repeated subtraction.
- Built as a datapath (A/B registers, subtractor, comparator) plus a Moore controller FSM.
- Both operands arrive serially on one shared input bus, A first, then B.
- Result appears on a_out with a done flag; used as a standalone arithmetic engine under a host that drives start/data_in.

Parameters:
- WIDTH, 16, operand/result bit width (unsigned).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level request; sampled in IDLE to begin a run.
- data_in  input  WIDTH  operand bus; A sampled in LOAD_A, B sampled in LOAD_B.
- a_out  output  WIDTH  live contents of register A; equals the GCD while done=1.
- done  output  1  registered; high only in state DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, A=0, B=0, done=0, a_out=0. Reset asserted mid-run aborts immediately; no partial result is kept.
- IDLE:
  - done=0.
  - If start=1 at a clk edge, go to LOAD_A; otherwise stay.
- LOAD_A: at the next edge, A<=data_in; go to LOAD_B. start is ignored.
- LOAD_B: at the next edge, B<=data_in; go to CALC.
- CALC: one compare/update per cycle, using the current A and B:
  - A==B -> go to DONE; A unchanged.
  - A==0 (B!=0) -> A<=B; go to DONE, so gcd(0,x)=x.
  - B==0 (A!=0) -> go to DONE with A unchanged, so gcd(x,0)=x.
  - A>B -> A<=A-B; stay in CALC.
  - A<B -> B<=B-A; stay in CALC.
  - gcd(0,0)=0, via the A==B rule.
  - The subtractor is WIDTH-bit; it never underflows because the larger operand is always the minuend.
- DONE:
  - done=1; A and B hold; a_out=GCD.
  - If start=0 at an edge, go to IDLE, where done drops to 0.
  - While start stays 1, remain in DONE; a held-high start never auto-restarts.
- Latency:
  - start sampled -> A load: 1 edge. B load: 1 more edge.
  - Then N+1 CALC edges, where N is the number of subtractions; done is high after that final edge.
  - Example: 143/78 needs N=6, so DONE is entered 7 edges after B loads.
- data_in only needs to be stable at the LOAD_A and LOAD_B edges.
- a_out is observable in every state; it shows intermediate A values during CALC.
- No illegal-state lockup: any unused state encoding returns to IDLE.

Decomposition:
- Package gcd_pkg: WIDTH default constant; state enum {IDLE, LOAD_A, LOAD_B, CALC, DONE}.
- Sub-module gcd_dp (datapath):
  - A/B registers with load enables.
  - Input select: data_in or difference.
  - Subtractor operand select.
  - Comparator status outputs lt/gt/eq plus a_zero/b_zero.
- Top gcd_engine holds the controller FSM driving ldA, ldB, sel1, sel2, sel_in.

Test Plan:
- rst pulse, then start=1; data_in=143 at the LOAD_A edge, 78 at the LOAD_B edge -> a_out sequence 143,65,65,52,39,26,13; done=1 with a_out=13 seven edges after B loads.
- Operands 48,18 -> done=1, a_out=6. Then drop start -> IDLE, done=0. Rerun with 35,64 -> a_out=1.
- Operands 17,17 -> done=1 on the first CALC edge, a_out=17.
- Zero cases:
  - 0,25 -> a_out=25.
  - 40,0 -> a_out=40.
  - 0,0 -> a_out=0.
  - Each reaches DONE within 1 CALC edge.
- Keep start=1 after DONE for 20 cycles -> done stays 1 and a_out stays fixed, with no reload from data_in.
- Assert rst asynchronously mid-CALC (between edges) -> done=0, a_out=0 immediately. A new run with 143,78 then still yields 13.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gcd_pkg;

   localparam int GCD_WIDTH = 16;

   // Controller states; the three unused encodings fall back to IDLE.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      CALC   = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/gcd_dp.sv
// GCD datapath: A/B operand registers, one shared subtractor, magnitude/zero status.
// Latency: registers update on the edge their load enable is high; status is combinational.
// Backpressure: none; every control input is obeyed on the cycle it is presented.
//
// Ports: clk/rst (async active-high); data_in operand bus; ld_a/ld_b load enables;
//        sel_in picks data_in (1) or the difference (0) as the register input;
//        sel1 picks the minuend (0=A, 1=B), sel2 the subtrahend (0=B, 1=A);
//        a_out mirrors register A; lt/gt/eq compare A with B; a_zero/b_zero flag zero operands.
module gcd_dp #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ld_a,
   input  logic             ld_b,
   input  logic             sel1,
   input  logic             sel2,
   input  logic             sel_in,
   output logic [WIDTH-1:0] a_out,
   output logic             lt,
   output logic             gt,
   output logic             eq,
   output logic             a_zero,
   output logic             b_zero
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sub_x;
   logic [WIDTH-1:0] sub_y;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] reg_in;

   // The controller always orders the operands larger-minus-smaller, so the
   // WIDTH-bit difference cannot wrap. B-0 doubles as the "copy B into A" path.
   assign sub_x  = sel1 ? b_q : a_q;
   assign sub_y  = sel2 ? a_q : b_q;
   assign diff   = sub_x - sub_y;
   assign reg_in = sel_in ? data_in : diff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (ld_a) a_q <= reg_in;
         if (ld_b) b_q <= reg_in;
      end
   end

   assign a_out  = a_q;
   assign lt     = (a_q <  b_q);
   assign gt     = (a_q >  b_q);
   assign eq     = (a_q == b_q);
   assign a_zero = (a_q == '0);
   assign b_zero = (b_q == '0);

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine: serial A/B load on data_in, result on a_out while done=1.
// Latency: 2 load edges after start, then N+1 compute edges for N subtractions.
// Backpressure: none; result held in DONE until the host drops start.
//
// Ports: clk, rst (async active-high); start level request; data_in operand bus
//        (A at the LOAD_A edge, B at the LOAD_B edge); a_out live register A;
//        done registered, high only in DONE.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] a_out,
   output logic             done
);

   state_t state;
   state_t state_nxt;

   logic ld_a;
   logic ld_b;
   logic sel1;
   logic sel2;
   logic sel_in;
   logic lt;
   logic gt;
   logic eq;
   logic a_zero;
   logic b_zero;

   gcd_dp #(.WIDTH(WIDTH)) u_dp (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .ld_a    (ld_a),
      .ld_b    (ld_b),
      .sel1    (sel1),
      .sel2    (sel2),
      .sel_in  (sel_in),
      .a_out   (a_out),
      .lt      (lt),
      .gt      (gt),
      .eq      (eq),
      .a_zero  (a_zero),
      .b_zero  (b_zero)
   );

   // done is a flop tracking the next state, so it is high exactly while in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt = state;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      sel1      = 1'b0;
      sel2      = 1'b0;
      sel_in    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LOAD_A;
         end
         LOAD_A: begin
            ld_a      = 1'b1;
            sel_in    = 1'b1;
            state_nxt = LOAD_B;
         end
         LOAD_B: begin
            ld_b      = 1'b1;
            sel_in    = 1'b1;
            state_nxt = CALC;
         end
         CALC: begin
            // Zero checks precede the magnitude compare: a zero operand would
            // otherwise look like an ordinary lt/gt and subtract forever.
            if (eq) begin
               state_nxt = DONE;
            end else if (a_zero) begin
               ld_a      = 1'b1;      // A <= B - 0
               sel1      = 1'b1;
               sel2      = 1'b1;
               state_nxt = DONE;
            end else if (b_zero) begin
               state_nxt = DONE;
            end else if (gt) begin
               ld_a      = 1'b1;      // A <= A - B
            end else if (lt) begin
               ld_b      = 1'b1;      // B <= B - A
               sel1      = 1'b1;
               sel2      = 1'b1;
            end
         end
         DONE: begin
            if (!start) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: scoreboard of expected GCDs plus
// per-scenario checks of latency, intermediate values, hold and reset.
// Clock period 10; inputs driven on the falling edge, outputs sampled there too.
module tb_gcd_engine;

   localparam int W      = 16;
   localparam int BUDGET = 200;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] data_in;
   logic [W-1:0] a_out;
   logic         done;

   int n_checks;
   int n_fail;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] trace_q[$];

   gcd_engine #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .data_in (data_in),
      .a_out   (a_out),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference GCD by Euclid's remainder method.
   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Number of CALC edges the subtractive algorithm needs (subtractions + 1).
   function automatic int ref_edges(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y;
      int n;
      x = a;
      y = b;
      n = 0;
      forever begin
         n++;
         if (x == y || x == 0 || y == 0) break;
         if (x > y) x = x - y;
         else       y = y - x;
      end
      return n;
   endfunction

   // Drive one run from IDLE; leaves start=1 with the DUT in DONE (or timed out).
   // trace_q receives a_out after the B-load edge and after every CALC edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int edges, output bit timed_out);
      exp_q.push_back(ref_gcd(a, b));
      trace_q.delete();
      @(negedge clk);
      start   = 1'b1;
      data_in = a;
      @(posedge clk);            // start sampled -> LOAD_A
      @(negedge clk);
      data_in = a;
      @(posedge clk);            // A loaded -> LOAD_B
      @(negedge clk);
      data_in = b;
      @(posedge clk);            // B loaded -> CALC
      @(negedge clk);
      data_in = ~b;              // later edges must not depend on data_in
      trace_q.push_back(a_out);
      edges     = 0;
      timed_out = 1'b1;
      while (edges < BUDGET) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
         trace_q.push_back(a_out);
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      start   = 1'b0;
      data_in = '0;
      #12;
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_done: got %b want 0", done);
      end
      n_checks++;
      if (a_out !== '0) begin
         n_fail++;
         $display("FAIL reset_a_out: got %0d want 0", a_out);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sequence_143_78();
      logic [W-1:0] want_seq[7];
      logic [W-1:0] exp;
      int  edges;
      bit  to;
      want_seq = '{16'd143, 16'd65, 16'd65, 16'd52, 16'd39, 16'd26, 16'd13};
      run_op(16'd143, 16'd78, edges, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || edges != 7) begin
         n_fail++;
         $display("FAIL seq_latency: got %0d edges (timeout=%0b) want 7", edges, to);
      end
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (i >= trace_q.size() || trace_q[i] !== want_seq[i]) begin
            n_fail++;
            $display("FAIL seq_a_out[%0d]: got %0d want %0d", i,
                     (i < trace_q.size()) ? trace_q[i] : '0, want_seq[i]);
         end
      end
      n_checks++;
      if (a_out !== exp || exp !== 16'd13) begin
         n_fail++;
         $display("FAIL seq_result: got %0d want %0d", a_out, exp);
      end
      go_idle();
   endtask

   task automatic test_basic();
      logic [W-1:0] ops[2][2];
      logic [W-1:0] exp;
      int  edges;
      bit  to;
      ops = '{'{16'd48, 16'd18}, '{16'd35, 16'd64}};
      for (int k = 0; k < 2; k++) begin
         run_op(ops[k][0], ops[k][1], edges, to);
         exp = exp_q.pop_front();
         n_checks++;
         if (to || !done || a_out !== exp) begin
            n_fail++;
            $display("FAIL basic_%0d_%0d: got a_out=%0d done=%b want %0d",
                     ops[k][0], ops[k][1], a_out, done, exp);
         end
         n_checks++;
         if (edges != ref_edges(ops[k][0], ops[k][1])) begin
            n_fail++;
            $display("FAIL basic_latency_%0d: got %0d want %0d", k, edges,
                     ref_edges(ops[k][0], ops[k][1]));
         end
         go_idle();
         n_checks++;
         if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_done_%0d: got %b want 0", k, done);
         end
      end
   endtask

   task automatic test_edge_cases();
      logic [W-1:0] ops[4][2];
      logic [W-1:0] want[4];
      logic [W-1:0] exp;
      int  edges;
      bit  to;
      ops  = '{'{16'd17, 16'd17}, '{16'd0, 16'd25}, '{16'd40, 16'd0}, '{16'd0, 16'd0}};
      want = '{16'd17, 16'd25, 16'd40, 16'd0};
      for (int k = 0; k < 4; k++) begin
         run_op(ops[k][0], ops[k][1], edges, to);
         exp = exp_q.pop_front();
         n_checks++;
         if (to || !done || a_out !== want[k] || a_out !== exp) begin
            n_fail++;
            $display("FAIL edge_%0d_%0d: got a_out=%0d done=%b want %0d",
                     ops[k][0], ops[k][1], a_out, done, want[k]);
         end
         n_checks++;
         if (edges != 1) begin
            n_fail++;
            $display("FAIL edge_latency_%0d: got %0d want 1", k, edges);
         end
         go_idle();
      end
   endtask

   task automatic test_hold_start();
      logic [W-1:0] exp;
      int  edges;
      bit  to;
      run_op(16'd91, 16'd56, edges, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || a_out !== exp) begin
         n_fail++;
         $display("FAIL hold_result: got %0d want %0d", a_out, exp);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         data_in = W'($urandom_range(1, 1000));
         @(posedge clk);
         @(negedge clk);
         n_checks++;
         if (done !== 1'b1 || a_out !== exp) begin
            n_fail++;
            $display("FAIL hold_cycle_%0d: got done=%b a_out=%0d want 1/%0d",
                     c, done, a_out, exp);
         end
      end
      go_idle();
   endtask

   task automatic test_async_reset();
      logic [W-1:0] exp;
      int  edges;
      bit  to;
      // Partial run abandoned mid-CALC; its expectation is never queued.
      @(negedge clk);
      start   = 1'b1;
      data_in = 16'd143;
      repeat (2) @(posedge clk);
      @(negedge clk);
      data_in = 16'd78;
      repeat (4) @(posedge clk);   // B load + 3 CALC edges
      #2;
      rst   = 1'b1;
      start = 1'b0;
      #1;
      n_checks++;
      if (done !== 1'b0 || a_out !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got done=%b a_out=%0d want 0/0", done, a_out);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(16'd143, 16'd78, edges, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || a_out !== exp || edges != 7) begin
         n_fail++;
         $display("FAIL post_reset_run: got a_out=%0d edges=%0d want %0d/7",
                  a_out, edges, exp);
      end
      go_idle();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_sequence_143_78();
      test_basic();
      test_edge_cases();
      test_hold_start();
      test_async_reset();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
